// File: rtl/write_audio.sv
// Output byte packer: pops one left/right quantized sample pair, dequantizes to 16-bit PCM,
// and streams L lo, L hi, R lo, R hi into the host byte FIFO. Build option: WRITE_AUDIO_SAT_EN.
module write_audio #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int CHAR_SIZE = 16,
  parameter int BITS      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] left_in_dout,
  input  logic                 left_in_empty,
  output logic                 left_in_rd_en,
  input  logic [DATA_SIZE-1:0] right_in_dout,
  input  logic                 right_in_empty,
  output logic                 right_in_rd_en,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [BYTE_SIZE-1:0] data_out,
  output logic [31:0]          frame_count
);

  typedef enum logic [2:0] {S_LOAD, S_B0, S_B1, S_B2, S_B3} state_t;

  state_t               state_q, state_d;
  logic [CHAR_SIZE-1:0] left_q, left_d;
  logic [CHAR_SIZE-1:0] right_q, right_d;
  logic [31:0]          frame_count_q, frame_count_d;
  logic                 pop;

`ifdef WRITE_AUDIO_SAT_EN
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = (DATA_SIZE'(1) <<< (CHAR_SIZE - 1)) - DATA_SIZE'(1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = -SAT_MAX - DATA_SIZE'(1);
`endif

  // Floor-divide by 2^BITS, then either clamp or wrap into CHAR_SIZE bits.
  function automatic logic [CHAR_SIZE-1:0] convert(input logic [DATA_SIZE-1:0] dout);
    logic signed [DATA_SIZE-1:0] s;
    s = $signed(dout) >>> BITS;
`ifdef WRITE_AUDIO_SAT_EN
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
`endif
    return s[CHAR_SIZE-1:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    left_d        = left_q;
    right_d       = right_q;
    frame_count_d = frame_count_q;
    pop           = 1'b0;
    out_wr_en     = 1'b0;
    data_out      = '0;
    case (state_q)
      S_LOAD: begin
        if (!left_in_empty && !right_in_empty) begin
          pop     = 1'b1;
          left_d  = convert(left_in_dout);
          right_d = convert(right_in_dout);
          state_d = S_B0;
        end
      end
      S_B0: begin
        data_out  = left_q[BYTE_SIZE-1:0];
        out_wr_en = !out_full;
        if (!out_full) state_d = S_B1;
      end
      S_B1: begin
        data_out  = left_q[2*BYTE_SIZE-1:BYTE_SIZE];
        out_wr_en = !out_full;
        if (!out_full) state_d = S_B2;
      end
      S_B2: begin
        data_out  = right_q[BYTE_SIZE-1:0];
        out_wr_en = !out_full;
        if (!out_full) state_d = S_B3;
      end
      S_B3: begin
        data_out  = right_q[2*BYTE_SIZE-1:BYTE_SIZE];
        out_wr_en = !out_full;
        if (!out_full) begin
          frame_count_d = frame_count_q + 32'd1;
          state_d       = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      left_q        <= '0;
      right_q       <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      left_q        <= left_d;
      right_q       <= right_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Pops are masked during reset so a held reset never drains the FIFOs.
  assign left_in_rd_en  = pop & ~reset;
  assign right_in_rd_en = pop & ~reset;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_write_audio.sv
// Self-checking bench for write_audio: FWFT FIFO models on both inputs, byte scoreboard on the output.
module tb_write_audio;
  localparam int DW   = 32;
  localparam int BW   = 8;
  localparam int CW   = 16;
  localparam int BITS = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] left_in_dout = '0;
  logic          left_in_empty = 1'b1;
  logic          left_in_rd_en;
  logic [DW-1:0] right_in_dout = '0;
  logic          right_in_empty = 1'b1;
  logic          right_in_rd_en;
  logic          out_full = 1'b0;
  logic          out_wr_en;
  logic [BW-1:0] data_out;
  logic [31:0]   frame_count;

  write_audio #(.DATA_SIZE(DW), .BYTE_SIZE(BW), .CHAR_SIZE(CW), .BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .left_in_dout(left_in_dout), .left_in_empty(left_in_empty), .left_in_rd_en(left_in_rd_en),
    .right_in_dout(right_in_dout), .right_in_empty(right_in_empty), .right_in_rd_en(right_in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .data_out(data_out), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [BW-1:0] exp_q[$];
  int            wr_cyc_q[$];
  int            pop_cyc_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            n_pops = 0;
  int            n_wr = 0;
  int            exp_frames = 0;
  logic          pend = 1'b0;
  logic [BW-1:0] exp_b;
  logic [DW-1:0] junk;

  // Output monitor and scoreboard; also checks the pop pairing rule every cycle.
  always @(negedge clock) begin
    cyc++;
    n_checks++;
    if (left_in_rd_en !== right_in_rd_en) begin
      n_fail++;
      $display("FAIL rd_en_pair cyc=%0d left=%b right=%b", cyc, left_in_rd_en, right_in_rd_en);
    end
    if (left_in_rd_en === 1'b1) begin
      n_pops++;
      pop_cyc_q.push_back(cyc);
      n_checks++;
      if (left_in_empty || right_in_empty) begin
        n_fail++;
        $display("FAIL pop_when_empty cyc=%0d l_empty=%b r_empty=%b", cyc, left_in_empty, right_in_empty);
      end
    end
    if (out_wr_en === 1'b1) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      n_checks++;
      if (reset || out_full) begin
        n_fail++;
        $display("FAIL write_blocked cyc=%0d reset=%b out_full=%b", cyc, reset, out_full);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d got=%h expected none", cyc, data_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b) begin
          n_fail++;
          $display("FAIL byte cyc=%0d got=%h expected=%h", cyc, data_out, exp_b);
        end
      end
    end
    pend = left_in_rd_en;
  end

  // FWFT FIFO models: pop just after the edge that consumed the head, then refresh head/empty.
  always @(posedge clock) begin
    #1;
    if (pend === 1'b1) begin
      if (lq.size() > 0) junk = lq.pop_front();
      if (rq.size() > 0) junk = rq.pop_front();
    end
    #1;
    left_in_empty  = (lq.size() == 0);
    left_in_dout   = (lq.size() > 0) ? lq[0] : '0;
    right_in_empty = (rq.size() == 0);
    right_in_dout  = (rq.size() > 0) ? rq[0] : '0;
  end

  function automatic logic [CW-1:0] model(input logic [DW-1:0] w);
    longint s;
    s = longint'($signed(w)) >>> BITS;
`ifdef WRITE_AUDIO_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[CW-1:0];
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_words(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lq.push_back(l);
    rq.push_back(r);
  endtask

  task automatic push_exp(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                          input logic [BW-1:0] b2, input logic [BW-1:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_frames++;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout remaining=%0d expected 0", exp_q.size());
    end
    tick(1);
  endtask

  task automatic wait_pop(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (left_in_rd_en === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL pop_timeout got none expected rd_en");
    end
  endtask

  task automatic check_frames(input string name);
    n_checks++;
    if (frame_count !== exp_frames) begin
      n_fail++;
      $display("FAIL %s frame_count got=%0d expected=%0d", name, frame_count, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_words(32'h0001_2000, 32'h0000_0400);
    tick(3);
    n_checks++;
    if ({left_in_rd_en, right_in_rd_en, out_wr_en, data_out, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rd=%b%b wr=%b data=%h fc=%0d expected all 0",
               left_in_rd_en, right_in_rd_en, out_wr_en, data_out, frame_count);
    end
    push_exp(8'h48, 8'h00, 8'h01, 8'h00);
    reset = 1'b0;
    wait_idle(50);
    check_frames("reset_release");
  endtask

  task automatic test_nominal();
    int p0;
    p0 = n_pops;
    wr_cyc_q.delete();
    pop_cyc_q.delete();
    push_words(32'h0004_B000, 32'hFFFF_EC00);
    push_exp(8'h2C, 8'h01, 8'hFB, 8'hFF);
    wait_idle(50);
    check_frames("nominal");
    n_checks++;
    if (n_pops - p0 != 1) begin
      n_fail++;
      $display("FAIL nominal_pops got=%0d expected=1", n_pops - p0);
    end
    n_checks++;
    if (wr_cyc_q.size() != 4 || pop_cyc_q.size() != 1) begin
      n_fail++;
      $display("FAIL nominal_counts writes=%0d pops=%0d expected 4 and 1", wr_cyc_q.size(), pop_cyc_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wr_cyc_q[k] != pop_cyc_q[0] + 1 + k) begin
          n_fail++;
          $display("FAIL nominal_timing byte%0d cyc=%0d expected=%0d", k, wr_cyc_q[k], pop_cyc_q[0] + 1 + k);
        end
      end
    end
  endtask

  task automatic test_floor();
    push_words(32'hFFFF_FFFF, 32'h0000_03FF);
    push_exp(8'hFF, 8'hFF, 8'h00, 8'h00);
    wait_idle(50);
    check_frames("floor");
  endtask

  task automatic test_saturation();
    push_words(32'h0200_0000, 32'hFDFF_FC00);
`ifdef WRITE_AUDIO_SAT_EN
    push_exp(8'hFF, 8'h7F, 8'h00, 8'h80);
`else
    push_exp(8'h00, 8'h80, 8'hFF, 8'h7F);
`endif
    wait_idle(50);
    check_frames("saturation");
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = n_wr;
    push_words(32'h0012_3400, 32'hFFF0_0000);
    push_exp(8'h8D, 8'h04, 8'h00, 8'hFC);
    wait_pop(50);
    tick(2);
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (out_wr_en !== 1'b0 || data_out !== 8'h04) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle%0d wr=%b data=%h expected wr=0 data=04", i, out_wr_en, data_out);
      end
    end
    @(posedge clock);
    #1;
    out_full = 1'b0;
    wait_idle(50);
    check_frames("backpressure");
    n_checks++;
    if (n_wr - w0 != 4) begin
      n_fail++;
      $display("FAIL backpressure_writes got=%0d expected=4", n_wr - w0);
    end
  endtask

  task automatic test_unbalanced();
    int p0;
    int w0;
    p0 = n_pops;
    w0 = n_wr;
    lq.push_back(32'h0000_0800);
    lq.push_back(32'h0000_0C00);
    tick(10);
    n_checks++;
    if (n_pops != p0 || n_wr != w0) begin
      n_fail++;
      $display("FAIL unbalanced_idle pops=%0d writes=%0d expected 0 and 0", n_pops - p0, n_wr - w0);
    end
    rq.push_back(32'h0000_1000);
    push_exp(8'h02, 8'h00, 8'h04, 8'h00);
    wait_idle(50);
    check_frames("unbalanced");
    n_checks++;
    if (lq.size() != 1) begin
      n_fail++;
      $display("FAIL unbalanced_left_level got=%0d expected=1", lq.size());
    end
    rq.push_back(32'h0000_1400);
    push_exp(8'h03, 8'h00, 8'h05, 8'h00);
    wait_idle(50);
    check_frames("unbalanced_drain");
  endtask

  task automatic test_reset_mid();
    push_words(32'h0000_2800, 32'h0000_2C00);
    push_exp(8'h0A, 8'h00, 8'h0B, 8'h00);
    wait_pop(50);
    tick(3);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({left_in_rd_en, right_in_rd_en, out_wr_en, data_out, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs rd=%b%b wr=%b data=%h fc=%0d expected all 0",
               left_in_rd_en, right_in_rd_en, out_wr_en, data_out, frame_count);
    end
    exp_q.delete();
    exp_frames = 0;
    push_words(32'h0000_3000, 32'h0000_3400);
    tick(2);
    n_checks++;
    if (left_in_rd_en !== 1'b0 || out_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold rd=%b wr=%b expected 0 0", left_in_rd_en, out_wr_en);
    end
    push_exp(8'h0C, 8'h00, 8'h0D, 8'h00);
    reset = 1'b0;
    wait_idle(50);
    check_frames("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [CW-1:0] ml;
    logic [CW-1:0] mr;
    wr_cyc_q.delete();
    pop_cyc_q.delete();
    for (int f = 0; f < 6; f++) begin
      l  = $urandom();
      r  = $urandom();
      ml = model(l);
      mr = model(r);
      push_words(l, r);
      push_exp(ml[7:0], ml[15:8], mr[7:0], mr[15:8]);
    end
    wait_idle(200);
    check_frames("back_to_back");
    n_checks++;
    if (wr_cyc_q.size() != 24 || pop_cyc_q.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_counts writes=%0d pops=%0d expected 24 and 6", wr_cyc_q.size(), pop_cyc_q.size());
    end else begin
      n_checks++;
      if (wr_cyc_q[23] - pop_cyc_q[0] != 29) begin
        n_fail++;
        $display("FAIL b2b_throughput span=%0d expected=29", wr_cyc_q[23] - pop_cyc_q[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_nominal();
    test_floor();
    test_saturation();
    test_backpressure();
    test_unbalanced();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
